// File: rtl/mmio_uart_ctrl_pkg.sv
// rtl/mmio_uart_ctrl_pkg.sv - MMIO window offsets and shared types for the uart/counter responder
// The core's address decode imports the same offsets so both sides agree on the map.
package mmio_uart_ctrl_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CRST   = 8'h18;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_FULL = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic       load;
    logic       store;
    logic [7:0] off;
  } mmio_req_t;

endpackage

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// rtl/mmio_uart_ctrl_sync_fifo.sv - single-clock FIFO buffering uart RX bytes
// Push is ignored when full and pop when empty; push+pop together keep the count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO responder for the core's data side: uart status/RX/TX and perf counters
// Loads return one cycle later, matching dmem latency.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE     = MMIO_BASE_DEFAULT,
  parameter int          RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr_i,
  input  logic        req_re_i,
  input  logic [3:0]  req_we_i,
  input  logic [31:0] req_wdata_i,
  output logic [31:0] rd_data_o,
  input  logic        inst_retired_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  mmio_req_t   req;
  logic        in_window;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic        tx_wr, cnt_clr;
  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        unused_bits;

  assign unused_bits = ^{req_addr_i[30:8], req_wdata_i[31:8]};

  // A store wins over a simultaneous load; the load side then leaves rd_data alone.
  assign in_window = (req_addr_i[31] == MMIO_BASE[31]);
  always_comb begin
    req.off   = req_addr_i[7:0];
    req.store = in_window & (|req_we_i);
    req.load  = in_window & req_re_i & ~(|req_we_i);
  end

  assign rx_ready_o = ~fifo_full;
  assign fifo_push  = rx_valid_i & rx_ready_o;
  assign fifo_pop   = req.load & (req.off == OFF_RX) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (rx_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A write landing while the holding register is full is lost, even in the drain cycle.
  assign tx_wr   = req.store & (req.off == OFF_TX) & (tx_state_q == TX_IDLE);
  assign cnt_clr = req.store & (req.off == OFF_CRST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (tx_wr)      tx_state_d = TX_FULL;
      TX_FULL: if (tx_ready_i) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = (tx_state_q == TX_FULL);
  end

  always_comb begin
    tx_data_d  = tx_wr ? req_wdata_i[7:0] : tx_data_q;
    cyc_cnt_d  = cnt_clr ? 32'h0 : cyc_cnt_q + 32'h1;
    inst_cnt_d = cnt_clr ? 32'h0 : inst_cnt_q + {31'h0, inst_retired_i};
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (req.load) begin
      case (req.off)
        OFF_STATUS: rd_data_d = {30'h0, ~fifo_empty, ~tx_valid_o};
        OFF_RX:     rd_data_d = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
        OFF_CYC:    rd_data_d = cyc_cnt_q;
        OFF_INST:   rd_data_d = inst_cnt_q;
        default:    rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= 8'h0;
      cyc_cnt_q  <= 32'h0;
      inst_cnt_q <= 32'h0;
      rd_data_q  <= 32'h0;
    end else begin
      tx_data_q  <= tx_data_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inst_cnt_q <= inst_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb/tb_mmio_uart_ctrl.sv - directed self-checking bench for mmio_uart_ctrl
module tb_mmio_uart_ctrl;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_re;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic [31:0] rd_data;
  logic        inst_retired;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.MMIO_BASE(32'h8000_0000), .RX_FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_addr_i     (req_addr),
    .req_re_i       (req_re),
    .req_we_i       (req_we),
    .req_wdata_i    (req_wdata),
    .rd_data_o      (rd_data),
    .inst_retired_i (inst_retired),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready)
  );

  // All tasks start and end on a negedge; outputs are sampled there.
  task automatic mmio_rd(input logic [31:0] addr, output logic [31:0] d);
    req_addr = addr; req_re = 1'b1; req_we = 4'h0;
    @(negedge clk);
    req_re = 1'b0;
    d = rd_data;
  endtask

  task automatic mmio_wr(input logic [31:0] addr, input logic [31:0] data);
    req_addr = addr; req_we = 4'hF; req_wdata = data; req_re = 1'b0;
    @(negedge clk);
    req_we = 4'h0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; req_addr = 0; req_re = 0; req_we = 0; req_wdata = 0;
    inst_retired = 0; rx_data = 0; rx_valid = 0; tx_ready = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want %h", rd_data, 32'h0); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_chk++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    rst = 1'b0;
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_after_reset: got %h want %h", d, 32'h1); end
    repeat (4) @(negedge clk);
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL cycle_after_reset: got %h want %h", d, 32'h5); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    mmio_wr(B | 32'h08, 32'h0000_0041);
    n_chk++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_set: got %b want 1", tx_valid); end
    n_chk++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data_load: got %h want 41", tx_data); end
    mmio_wr(B | 32'h08, 32'h0000_0042);
    n_chk++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_drop_busy: got %h want 41", tx_data); end
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL status_tx_busy: got %h want %h", d, 32'h0); end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_valid_clear: got %b want 0", tx_valid); end
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_tx_idle: got %h want %h", d, 32'h1); end
  endtask

  task automatic test_back_to_back();
    mmio_wr(B | 32'h08, 32'h0000_0055);
    tx_ready = 1'b1;
    mmio_wr(B | 32'h08, 32'h0000_0066);
    tx_ready = 1'b0;
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_valid: got %b want 0", tx_valid); end
    n_chk++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL b2b_tx_data: got %h want 55", tx_data); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    mmio_rd(B | 32'h00, d);
    mmio_rd(32'h0000_0010, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL non_mmio_hold: got %h want %h", d, 32'h1); end
    mmio_rd(B | 32'h0C, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", d, 32'h0); end
    mmio_wr(32'h0000_0008, 32'h0000_00EE);
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL non_mmio_store: got %b want 0", tx_valid); end
    req_addr = B | 32'h08; req_re = 1'b1; req_we = 4'h1; req_wdata = 32'h77;
    @(negedge clk);
    req_re = 1'b0; req_we = 4'h0;
    n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL re_we_rd_hold: got %h want %h", rd_data, 32'h0); end
    n_chk++; if (tx_data !== 8'h77) begin n_fail++; $display("FAIL re_we_store: got %h want 77", tx_data); end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_fifo();
    logic [31:0] d;
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL status_rx_avail: got %h want %h", d, 32'h3); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'h11) begin n_fail++; $display("FAIL rx_pop0: got %h want %h", d, 32'h11); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'h22) begin n_fail++; $display("FAIL rx_pop1: got %h want %h", d, 32'h22); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'h33) begin n_fail++; $display("FAIL rx_pop2: got %h want %h", d, 32'h33); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_pop_empty: got %h want %h", d, 32'h0); end
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_rx_empty: got %h want %h", d, 32'h1); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'hA0 + 8'(i); rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_data = 8'hA8;
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_ready: got %b want 0", rx_ready); end
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_hold: got %b want 0", rx_ready); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'hA0) begin n_fail++; $display("FAIL full_pop: got %h want %h", d, 32'hA0); end
    mmio_rd(B | 32'h04, d);
    rx_valid = 1'b0;
    n_chk++; if (d !== 32'hA1) begin n_fail++; $display("FAIL push_pop_same: got %h want %h", d, 32'hA1); end
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL push_pop_ready: got %b want 1", rx_ready); end
    for (int j = 2; j <= 8; j++) begin
      mmio_rd(B | 32'h04, d);
      n_chk++; if (d !== (32'hA0 + 32'(j))) begin n_fail++; $display("FAIL fifo_order_%0d: got %h want %h", j, d, 32'hA0 + 32'(j)); end
    end
    mmio_rd(B | 32'h00, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL fifo_drained: got %h want %h", d, 32'h1); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    for (int i = 0; i < 7; i++) begin
      inst_retired = 1'b1;
      @(negedge clk);
      inst_retired = 1'b0;
      @(negedge clk);
    end
    mmio_rd(B | 32'h14, d);
    n_chk++; if (d !== 32'h7) begin n_fail++; $display("FAIL inst_count: got %h want %h", d, 32'h7); end
    mmio_wr(B | 32'h18, 32'hDEAD_BEEF);
    mmio_rd(B | 32'h14, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL inst_clear: got %h want %h", d, 32'h0); end
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL cyc_clear: got %h want %h", d, 32'h1); end
    force dut.cyc_cnt_q = 32'hFFFF_FFFE;
    release dut.cyc_cnt_q;
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cyc_near_wrap: got %h want %h", d, 32'hFFFF_FFFE); end
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_max: got %h want %h", d, 32'hFFFF_FFFF); end
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    rx_push(8'h5A); rx_push(8'h5B); rx_push(8'h5C);
    mmio_wr(B | 32'h08, 32'h0000_0099);
    n_chk++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tx: got %b want 1", tx_valid); end
    rst = 1'b1; req_addr = B | 32'h10; req_re = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_re = 1'b0;
    n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_inflight_rd: got %h want %h", rd_data, 32'h0); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_chk++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
    mmio_rd(B | 32'h04, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_rx_empty: got %h want %h", d, 32'h0); end
    mmio_rd(B | 32'h10, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL rst_cyc: got %h want %h", d, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_decode();
    test_rx_fifo();
    test_fifo_full();
    test_counters();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
